// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: word geometry, default boot address and the
// {instruction, PC} entry carried from the fetch front-end to logic_control.
package cpu_pkg;

  localparam int          WORD_BYTES           = 4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous prefetch FIFO with flush, occupancy count and a registered head
// entry that holds its last value once the buffer runs empty.
module prefetch_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] next_rd_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] remain_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_nxt_s;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Accept/occupancy bookkeeping and the entry that becomes head after this edge
  always_comb begin
    pop_ok_s    = pop & (count_r != '0);
    push_ok_s   = push & ((count_r != CNT_W'(DEPTH)) | pop_ok_s);
    next_rd_s   = rd_ptr_r + PTR_W'(1);
    remain_s    = count_r - {{PTR_W{1'b0}}, pop_ok_s};
    count_nxt_s = remain_s + {{PTR_W{1'b0}}, push_ok_s};
    if ((count_r != '0) && !pop_ok_s) begin
      head_nxt_s = head_r;
    end else if (remain_s != '0) begin
      head_nxt_s = mem_r[next_rd_s];
    end else if (push_ok_s) begin
      head_nxt_s = push_data;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Pointers, count and head register; flush wins over a concurrent push/pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= next_rd_s;
      count_r <= count_nxt_s;
      head_r  <= head_nxt_s;
    end
  end

  // Entry storage needs no reset: it is only read behind a non-zero count
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) mem_r[wr_ptr_r] <= push_data;
  end

  assign head_valid = (count_r != '0);
  assign head_data  = head_r;
  assign count      = count_r;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Autonomous sequential instruction fetcher: credit-limited issue into a
// fixed-latency memory port, in-flight tracking, prefetch buffer, branch flush.
module instr_prefetch_unit
  import cpu_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter int                DEPTH        = 4,
  parameter int                MEM_LATENCY  = 1,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_grant,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   redirect_en,
  input  logic [ADDR_W-1:0]      redirect_addr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [DATA_W-1:0]      instr_data,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int SUM_W = $clog2(DEPTH + MEM_LATENCY + 1) + 1;

  logic [ADDR_W-1:0]        fetch_pc_r;
  logic [MEM_LATENCY-1:0]   pipe_valid_r;
  logic [ADDR_W-1:0]        pipe_pc_r [MEM_LATENCY];
  logic [MEM_LATENCY:0]     shift_s;
  logic [SUM_W-1:0]         inflight_s;
  logic [SUM_W-1:0]         credit_s;
  logic                     issue_s;
  logic [DATA_W+ADDR_W-1:0] head_s;
  logic                     unused_s;

  // Issue only when every buffered and outstanding word still has a free slot
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight_s = inflight_s + SUM_W'(pipe_valid_r[i]);
    end
    credit_s = SUM_W'(fill_level) + inflight_s;
    issue_s  = mem_grant & ~redirect_en & reset & (credit_s < SUM_W'(DEPTH));
    shift_s  = {pipe_valid_r, issue_s};
  end

  assign mem_rd_en = issue_s;
  assign mem_addr  = fetch_pc_r;
  assign unused_s  = ^redirect_addr[1:0];

  // Sequential fetch address, restarted word-aligned on redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= RESET_VECTOR;
    end else if (redirect_en) begin
      fetch_pc_r <= {redirect_addr[ADDR_W-1:2], 2'b00};
    end else if (issue_s) begin
      fetch_pc_r <= fetch_pc_r + ADDR_W'(WORD_BYTES);
    end
  end

  // In-flight pipe mirrors the memory latency; redirect kills outstanding returns
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid_r <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) pipe_pc_r[i] <= '0;
    end else begin
      pipe_valid_r <= redirect_en ? '0 : shift_s[MEM_LATENCY-1:0];
      pipe_pc_r[0] <= fetch_pc_r;
      for (int i = 1; i < MEM_LATENCY; i++) pipe_pc_r[i] <= pipe_pc_r[i-1];
    end
  end

  prefetch_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (pipe_valid_r[MEM_LATENCY-1]),
    .push_data  ({mem_rdata, pipe_pc_r[MEM_LATENCY-1]}),
    .pop        (instr_ready),
    .flush      (redirect_en),
    .head_valid (instr_valid),
    .head_data  (head_s),
    .count      (fill_level)
  );

  assign instr_data = head_s[DATA_W+ADDR_W-1:ADDR_W];
  assign instr_pc   = head_s[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: instance 0 is DEPTH=4/LAT=1/vector 0, instance 1
// is DEPTH=8/LAT=3/vector 0xFFFFFFF8; expected PCs are queued and matched on delivery.
module tb_instr_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        grant [2];
  logic        rd_en [2];
  logic [31:0] addr  [2];
  logic [31:0] rdata [2];
  logic        redir [2];
  logic [31:0] raddr [2];
  logic        valid [2];
  logic        ready [2];
  logic [31:0] idata [2];
  logic [31:0] ipc   [2];
  logic [2:0]  fill0;
  logic [3:0]  fill1;
  logic [31:0] mreq  [2][3];
  logic        mvld  [2][3];

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          cyc = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got_pc [$];
  logic [31:0] got_data [$];
  int          got_cyc [$];
  logic [31:0] iss_q [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic int dep(input int u);
    return (u == 0) ? 4 : 8;
  endfunction

  function automatic int lat(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] vec(input int u);
    return (u == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
  endfunction

  function automatic logic [3:0] fill_of(input int u);
    return (u == 0) ? {1'b0, fill0} : fill1;
  endfunction

  instr_prefetch_unit #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(4), .MEM_LATENCY(1), .RESET_VECTOR(32'h0000_0000)
  ) dut0 (
    .clk(clk), .reset(rst[0]), .mem_grant(grant[0]), .mem_rd_en(rd_en[0]),
    .mem_addr(addr[0]), .mem_rdata(rdata[0]), .redirect_en(redir[0]),
    .redirect_addr(raddr[0]), .instr_valid(valid[0]), .instr_ready(ready[0]),
    .instr_data(idata[0]), .instr_pc(ipc[0]), .fill_level(fill0)
  );

  instr_prefetch_unit #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(8), .MEM_LATENCY(3), .RESET_VECTOR(32'hFFFF_FFF8)
  ) dut1 (
    .clk(clk), .reset(rst[1]), .mem_grant(grant[1]), .mem_rd_en(rd_en[1]),
    .mem_addr(addr[1]), .mem_rdata(rdata[1]), .redirect_en(redir[1]),
    .redirect_addr(raddr[1]), .instr_valid(valid[1]), .instr_ready(ready[1]),
    .instr_data(idata[1]), .instr_pc(ipc[1]), .fill_level(fill1)
  );

  // Fixed-latency memory: returns word_of(address) LAT cycles after the request
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      mreq[u][0] <= addr[u];
      mvld[u][0] <= rd_en[u];
      for (int k = 1; k < 3; k++) begin
        mreq[u][k] <= mreq[u][k-1];
        mvld[u][k] <= mvld[u][k-1];
      end
    end
  end

  assign rdata[0] = word_of(mreq[0][0]);
  assign rdata[1] = word_of(mreq[1][2]);

  // One cycle: inputs already driven; sample just after the negedge, then advance
  task automatic step(input int u);
    #1;
    if (valid[u] && ready[u]) begin
      got_pc.push_back(ipc[u]);
      got_data.push_back(idata[u]);
      got_cyc.push_back(cyc);
    end
    if (rd_en[u]) iss_q.push_back(addr[u]);
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset(input int u);
    rst[u]   = 1'b0;
    grant[u] = 1'b0;
    ready[u] = 1'b0;
    redir[u] = 1'b0;
    raddr[u] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    got_pc.delete();
    got_data.delete();
    got_cyc.delete();
    iss_q.delete();
    rst[u] = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      chk_cnt++;
      if (rd_en[u] !== 1'b0) $display("FAIL reset_rd_en u%0d: got %b want 0", u, rd_en[u]); else pass_cnt++;
      chk_cnt++;
      if (addr[u] !== vec(u)) $display("FAIL reset_addr u%0d: got %h want %h", u, addr[u], vec(u)); else pass_cnt++;
      chk_cnt++;
      if (valid[u] !== 1'b0) $display("FAIL reset_valid u%0d: got %b want 0", u, valid[u]); else pass_cnt++;
      chk_cnt++;
      if (idata[u] !== 32'h0 || ipc[u] !== 32'h0)
        $display("FAIL reset_head u%0d: got data %h pc %h want 0 0", u, idata[u], ipc[u]);
      else pass_cnt++;
      chk_cnt++;
      if (fill_of(u) !== 4'd0) $display("FAIL reset_fill u%0d: got %0d want 0", u, fill_of(u)); else pass_cnt++;
    end
  endtask

  task automatic test_stream(input int u);
    logic [31:0] e, g, d;
    apply_reset(u);
    grant[u] = 1'b1;
    ready[u] = 1'b1;
    for (int k = 0; k < 14 - (lat(u) + 1); k++) exp_q.push_back(vec(u) + 32'(4 * k));
    for (int c = 0; c < 14; c++) step(u);
    grant[u] = 1'b0;
    ready[u] = 1'b0;
    chk_cnt++;
    if (iss_q.size() !== 14) $display("FAIL stream_issues u%0d: got %0d want 14", u, iss_q.size()); else pass_cnt++;
    for (int k = 0; k < iss_q.size(); k++) begin
      chk_cnt++;
      if (iss_q[k] !== vec(u) + 32'(4 * k))
        $display("FAIL stream_addr u%0d #%0d: got %h want %h", u, k, iss_q[k], vec(u) + 32'(4 * k));
      else pass_cnt++;
    end
    chk_cnt++;
    if (got_pc.size() !== exp_q.size())
      $display("FAIL stream_count u%0d: got %0d want %0d", u, got_pc.size(), exp_q.size());
    else pass_cnt++;
    if (got_cyc.size() > 0) begin
      chk_cnt++;
      if (got_cyc[0] !== lat(u) + 1)
        $display("FAIL stream_first_cycle u%0d: got %0d want %0d", u, got_cyc[0], lat(u) + 1);
      else pass_cnt++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (got_pc.size() == 0) $display("FAIL stream_missing u%0d: got none want pc %h", u, e);
      else begin
        g = got_pc.pop_front();
        d = got_data.pop_front();
        if (g !== e || d !== word_of(e))
          $display("FAIL stream_order u%0d: got pc %h data %h want pc %h data %h", u, g, d, e, word_of(e));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_stall(input int u);
    logic [31:0] e, g, d;
    apply_reset(u);
    grant[u] = 1'b1;
    for (int c = 0; c < dep(u) + lat(u) + 4; c++) step(u);
    #1;
    chk_cnt++;
    if (iss_q.size() !== dep(u)) $display("FAIL stall_issues u%0d: got %0d want %0d", u, iss_q.size(), dep(u)); else pass_cnt++;
    chk_cnt++;
    if (fill_of(u) !== 4'(dep(u))) $display("FAIL stall_fill u%0d: got %0d want %0d", u, fill_of(u), dep(u)); else pass_cnt++;
    chk_cnt++;
    if (rd_en[u] !== 1'b0) $display("FAIL stall_rd_en u%0d: got %b want 0", u, rd_en[u]); else pass_cnt++;
    chk_cnt++;
    if (valid[u] !== 1'b1 || ipc[u] !== vec(u))
      $display("FAIL stall_head u%0d: got valid %b pc %h want 1 %h", u, valid[u], ipc[u], vec(u));
    else pass_cnt++;
    ready[u] = 1'b1;
    for (int c = 0; c < 2 * dep(u) + lat(u) + 4; c++) step(u);
    grant[u] = 1'b0;
    for (int c = 0; c < lat(u) + 4; c++) step(u);
    ready[u] = 1'b0;
    if (iss_q.size() > dep(u)) begin
      chk_cnt++;
      if (iss_q[dep(u)] !== vec(u) + 32'(4 * dep(u)))
        $display("FAIL stall_resume u%0d: got %h want %h", u, iss_q[dep(u)], vec(u) + 32'(4 * dep(u)));
      else pass_cnt++;
    end
    chk_cnt++;
    if (got_pc.size() !== iss_q.size() || got_pc.size() < dep(u) + 4)
      $display("FAIL stall_count u%0d: got %0d delivered want %0d (>= %0d)", u, got_pc.size(), iss_q.size(), dep(u) + 4);
    else pass_cnt++;
    for (int k = 0; k < dep(u) + 4; k++) exp_q.push_back(vec(u) + 32'(4 * k));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (got_pc.size() == 0) $display("FAIL stall_missing u%0d: got none want pc %h", u, e);
      else begin
        g = got_pc.pop_front();
        d = got_data.pop_front();
        if (g !== e || d !== word_of(e))
          $display("FAIL stall_order u%0d: got pc %h data %h want pc %h data %h", u, g, d, e, word_of(e));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_redirect(input int u);
    logic [31:0] e, g, d;
    int          p;
    p = (u == 0) ? 3 : 6;
    apply_reset(u);
    grant[u] = 1'b1;
    for (int c = 0; c < p; c++) step(u);
    redir[u] = 1'b1;
    raddr[u] = 32'h0000_0103;
    step(u);
    chk_cnt++;
    if (iss_q.size() !== p) $display("FAIL redirect_no_issue u%0d: got %0d issues want %0d", u, iss_q.size(), p); else pass_cnt++;
    redir[u] = 1'b0;
    ready[u] = 1'b1;
    #1;
    chk_cnt++;
    if (valid[u] !== 1'b0 || fill_of(u) !== 4'd0)
      $display("FAIL redirect_flush u%0d: got valid %b fill %0d want 0 0", u, valid[u], fill_of(u));
    else pass_cnt++;
    for (int c = 0; c < 12 + lat(u); c++) step(u);
    grant[u] = 1'b0;
    for (int c = 0; c < lat(u) + 3; c++) step(u);
    ready[u] = 1'b0;
    if (iss_q.size() > p) begin
      chk_cnt++;
      if (iss_q[p] !== 32'h0000_0100) $display("FAIL redirect_addr u%0d: got %h want 00000100", u, iss_q[p]); else pass_cnt++;
    end
    chk_cnt++;
    if (got_cyc.size() < 4 || got_cyc[0] !== p + lat(u) + 2)
      $display("FAIL redirect_latency u%0d: got %0d items first at %0d want first at %0d",
               u, got_cyc.size(), (got_cyc.size() > 0) ? got_cyc[0] : -1, p + lat(u) + 2);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h0000_0100 + 32'(4 * k));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (got_pc.size() == 0) $display("FAIL redirect_missing u%0d: got none want pc %h", u, e);
      else begin
        g = got_pc.pop_front();
        d = got_data.pop_front();
        if (g !== e || d !== word_of(e))
          $display("FAIL redirect_order u%0d: got pc %h data %h want pc %h data %h", u, g, d, e, word_of(e));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_grant_toggle();
    logic [31:0] e, g, d;
    int          bad, n0;
    bad = 0;
    apply_reset(0);
    ready[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      grant[0] = (c % 2 == 0);
      n0 = iss_q.size();
      step(0);
      if (!grant[0] && iss_q.size() != n0) bad++;
    end
    grant[0] = 1'b0;
    for (int c = 0; c < 4; c++) step(0);
    ready[0] = 1'b0;
    chk_cnt++;
    if (bad !== 0) $display("FAIL grant_gate: got %0d issues without grant want 0", bad); else pass_cnt++;
    chk_cnt++;
    if (iss_q.size() !== 10 || got_pc.size() !== 10)
      $display("FAIL grant_count: got %0d issues %0d delivered want 10 10", iss_q.size(), got_pc.size());
    else pass_cnt++;
    for (int k = 0; k < 10; k++) exp_q.push_back(32'(4 * k));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (got_pc.size() == 0) $display("FAIL grant_missing: got none want pc %h", e);
      else begin
        g = got_pc.pop_front();
        d = got_data.pop_front();
        if (g !== e || d !== word_of(e))
          $display("FAIL grant_order: got pc %h data %h want pc %h data %h", g, d, e, word_of(e));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_push_pop();
    logic [31:0] e, g, d;
    logic [3:0]  fb;
    logic        pp;
    int          n_pp;
    n_pp = 0;
    apply_reset(0);
    grant[0] = 1'b1;
    for (int c = 0; c < 8; c++) step(0);
    chk_cnt++;
    if (fill_of(0) !== 4'd4) $display("FAIL pushpop_full: got fill %0d want 4", fill_of(0)); else pass_cnt++;
    ready[0] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      pp = valid[0] & ready[0] & mvld[0][0];
      fb = fill_of(0);
      step(0);
      if (pp) begin
        n_pp++;
        chk_cnt++;
        if (fill_of(0) !== fb) $display("FAIL pushpop_fill: got %0d want %0d", fill_of(0), fb); else pass_cnt++;
      end
    end
    grant[0] = 1'b0;
    for (int c = 0; c < 5; c++) step(0);
    ready[0] = 1'b0;
    chk_cnt++;
    if (n_pp == 0 || got_pc.size() !== iss_q.size() || got_pc.size() < 12)
      $display("FAIL pushpop_count: got %0d overlaps %0d delivered %0d issued want >0 equal >=12",
               n_pp, got_pc.size(), iss_q.size());
    else pass_cnt++;
    for (int k = 0; k < 12; k++) exp_q.push_back(32'(4 * k));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (got_pc.size() == 0) $display("FAIL pushpop_missing: got none want pc %h", e);
      else begin
        g = got_pc.pop_front();
        d = got_data.pop_front();
        if (g !== e || d !== word_of(e))
          $display("FAIL pushpop_order: got pc %h data %h want pc %h data %h", g, d, e, word_of(e));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] e, g, d;
    apply_reset(1);
    grant[1] = 1'b1;
    ready[1] = 1'b1;
    for (int c = 0; c < 7; c++) step(1);
    #2;
    rst[1] = 1'b0;
    #1;
    chk_cnt++;
    if (rd_en[1] !== 1'b0 || addr[1] !== vec(1) || valid[1] !== 1'b0)
      $display("FAIL midrst_ctrl: got rd_en %b addr %h valid %b want 0 %h 0", rd_en[1], addr[1], valid[1], vec(1));
    else pass_cnt++;
    chk_cnt++;
    if (idata[1] !== 32'h0 || ipc[1] !== 32'h0 || fill1 !== 4'd0)
      $display("FAIL midrst_head: got data %h pc %h fill %0d want 0 0 0", idata[1], ipc[1], fill1);
    else pass_cnt++;
    @(negedge clk);
    exp_q.delete();
    got_pc.delete();
    got_data.delete();
    got_cyc.delete();
    iss_q.delete();
    rst[1] = 1'b1;
    cyc = 0;
    for (int c = 0; c < 12; c++) step(1);
    grant[1] = 1'b0;
    ready[1] = 1'b0;
    chk_cnt++;
    if (got_pc.size() !== 8) $display("FAIL midrst_count: got %0d want 8", got_pc.size()); else pass_cnt++;
    for (int k = 0; k < 8; k++) exp_q.push_back(vec(1) + 32'(4 * k));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (got_pc.size() == 0) $display("FAIL midrst_missing: got none want pc %h", e);
      else begin
        g = got_pc.pop_front();
        d = got_data.pop_front();
        if (g !== e || d !== word_of(e))
          $display("FAIL midrst_order: got pc %h data %h want pc %h data %h", g, d, e, word_of(e));
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u]   = 1'b1;
      grant[u] = 1'b1;
      ready[u] = 1'b1;
      redir[u] = 1'b0;
      raddr[u] = 32'h0;
    end
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    test_stream(0);
    test_stream(1);
    test_stall(0);
    test_stall(1);
    test_redirect(0);
    test_redirect(1);
    test_grant_toggle();
    test_push_pop();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
